bcrypt_data_mb: RTL

BCRYPT_DATA_MB -- requirements
Module: bcrypt_data_mb

---
 rtl/bcrypt_data_mb.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/bcrypt_data_mb.sv
// Multi-buffer batch FIFO that serializes 32-bit batch words onto the core bus.
// Optional checksum word appended to every batch when BCRYPT_DATA_CSUM_EN is defined.
module bcrypt_data_mb #(
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned NBUF      = 2,
  parameter int unsigned WORDS     = 31
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [31:0]          in_data,
  input  logic                 in_wr_en,
  input  logic [15:0]          in_pkt_id,
  input  logic                 in_gen_end,
  output logic                 in_full,
  output logic [OUT_WIDTH-1:0] dout,
  output logic [1:0]           ctrl,
  output logic                 data_ready,
  output logic [2:0]           ready_cnt,
  output logic [15:0]          bcdata_pkt_id,
  output logic                 bcdata_gen_end,
  input  logic                 start_data_tx,
  output logic                 data_tx_done,
  output logic [1:0]           error
);

  localparam logic [1:0]  CTRL_DATA_START = 2'b01;
  localparam logic [1:0]  CTRL_END        = 2'b10;
  localparam int unsigned RATIO = 32 / OUT_WIDTH;
  localparam int unsigned PW    = (NBUF > 1) ? $clog2(NBUF) : 1;
  localparam int unsigned AW    = (NBUF * WORDS > 1) ? $clog2(NBUF * WORDS) : 1;
  localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
`ifdef BCRYPT_DATA_CSUM_EN
  localparam int unsigned TX_WORDS = WORDS + 1;
`else
  localparam int unsigned TX_WORDS = WORDS;
`endif

  typedef enum logic [1:0] {StIdle, StStart, StTx, StDone} state_e;

  state_e          r_state, w_state_next;
  logic [PW-1:0]   r_fill_ptr, r_head_ptr;
  logic [6:0]      r_w, r_word;
  logic [CW-1:0]   r_chunk;
  logic [2:0]      r_ready_cnt;
  logic            r_busy;
  logic [1:0]      r_error;
  logic [OUT_WIDTH-1:0] r_dout;
  logic [31:0]     r_rdata;
  logic [15:0]     r_pkt  [2**PW];
  logic            r_gend [2**PW];
  logic [31:0]     r_mem  [2**AW];
`ifdef BCRYPT_DATA_CSUM_EN
  logic [31:0]     r_csum [2**PW];
`endif

  logic            w_full, w_wr_ok, w_ge_ok, w_commit, w_deq, w_last, w_chunk_end, w_rd_en;
  logic [6:0]      w_rd_word;
  logic [8:0]      w_waddr, w_raddr;
  logic [31:0]     w_word, w_shift;
  logic [OUT_WIDTH-1:0] w_beat;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NBUF - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_full      = ({1'b0, r_ready_cnt} + {3'b000, r_busy}) == 4'(NBUF);
    w_ge_ok     = in_gen_end & ~w_full;
    w_wr_ok     = in_wr_en & ~w_full & ~in_gen_end;
    w_commit    = w_ge_ok | (w_wr_ok && (r_w == 7'(WORDS - 1)));
    w_deq       = (r_state == StIdle) && start_data_tx && (r_ready_cnt != 3'd0);
    w_chunk_end = (r_chunk == CW'(RATIO - 1));
    w_last      = (r_state == StTx) && (r_word == 7'(TX_WORDS - 1)) && w_chunk_end;
    w_rd_word   = (r_state == StStart) ? 7'd0 : r_word + 7'd1;
    // Next payload word is fetched on the final chunk of the current one.
    w_rd_en     = (r_state == StStart) ||
                  ((r_state == StTx) && w_chunk_end && (w_rd_word < 7'(WORDS)));
    w_waddr     = 9'(r_fill_ptr) * 9'(WORDS) + {2'b00, r_w};
    w_raddr     = 9'(r_head_ptr) * 9'(WORDS) + {2'b00, w_rd_word};
`ifdef BCRYPT_DATA_CSUM_EN
    w_word      = (r_word == 7'(WORDS)) ? r_csum[r_head_ptr] : r_rdata;
`else
    w_word      = r_rdata;
`endif
    w_shift     = w_word >> (32'(r_chunk) * OUT_WIDTH);
    w_beat      = w_shift[OUT_WIDTH-1:0];
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_deq) w_state_next = r_gend[r_head_ptr] ? StDone : StStart;
      StStart: w_state_next = StTx;
      StTx:    if (w_last) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_fill_ptr  <= '0;
      r_head_ptr  <= '0;
      r_w         <= '0;
      r_word      <= '0;
      r_chunk     <= '0;
      r_ready_cnt <= '0;
      r_busy      <= 1'b0;
      r_error     <= '0;
      r_dout      <= '0;
      for (int i = 0; i < 2**PW; i++) begin
        r_pkt[i]  <= '0;
        r_gend[i] <= 1'b0;
`ifdef BCRYPT_DATA_CSUM_EN
        r_csum[i] <= '0;
`endif
      end
    end else begin
      if ((w_wr_ok && (r_w == 7'd0)) || w_ge_ok) begin
        r_pkt[r_fill_ptr]  <= in_pkt_id;
        r_gend[r_fill_ptr] <= w_ge_ok;
      end
`ifdef BCRYPT_DATA_CSUM_EN
      if (w_wr_ok) r_csum[r_fill_ptr] <= (r_w == 7'd0) ? in_data : r_csum[r_fill_ptr] ^ in_data;
`endif
      if (w_commit) begin
        r_w        <= '0;
        r_fill_ptr <= ptr_inc(r_fill_ptr);
      end else if (w_wr_ok) begin
        r_w <= r_w + 7'd1;
      end
      if (w_commit && !w_deq)      r_ready_cnt <= r_ready_cnt + 3'd1;
      else if (!w_commit && w_deq) r_ready_cnt <= r_ready_cnt - 3'd1;
      if (w_deq) r_busy <= 1'b1;
      if (r_state == StDone) begin
        r_busy     <= 1'b0;
        r_head_ptr <= ptr_inc(r_head_ptr);
      end
      if ((r_state == StIdle) && start_data_tx && (r_ready_cnt == 3'd0)) r_error[0] <= 1'b1;
      if (in_wr_en && w_full) r_error[1] <= 1'b1;
      if (r_state == StStart) begin
        r_word  <= '0;
        r_chunk <= '0;
      end else if (r_state == StTx) begin
        r_dout <= w_beat;
        if (w_chunk_end) begin
          r_chunk <= '0;
          r_word  <= r_word + 7'd1;
        end else begin
          r_chunk <= r_chunk + 1'b1;
        end
      end
    end
  end

  // Batch RAM: not reset, synchronous read.
  always_ff @(posedge CLK) begin
    if (w_wr_ok) r_mem[w_waddr[AW-1:0]] <= in_data;
    if (w_rd_en) r_rdata <= r_mem[w_raddr[AW-1:0]];
  end

  always_comb begin
    in_full        = w_full;
    dout           = (r_state == StTx) ? w_beat : r_dout;
    ctrl           = (r_state == StStart) ? CTRL_DATA_START : (w_last ? CTRL_END : 2'b00);
    data_ready     = (r_ready_cnt != 3'd0);
    ready_cnt      = r_ready_cnt;
    bcdata_pkt_id  = r_pkt[r_head_ptr];
    bcdata_gen_end = r_gend[r_head_ptr];
    data_tx_done   = (r_state == StDone);
    error          = r_error;
  end

endmodule
